// File: rtl/c1541_sd_server_if.sv
// Block-transfer bus of c1541_sd_server: the SD buffer side and the disk-image side.
// The master modport is the environment (initiator and image store); slave is the server.
interface c1541_sd_server_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [23:0] img_addr;
    logic        img_rd;
    logic        img_wr;
    logic [7:0]  img_din;
    logic [7:0]  img_dout;
    logic        img_ready;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, img_dout, img_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_addr, img_rd, img_wr, img_din
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_dout, img_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_addr, img_rd, img_wr, img_din
    );
endinterface

// File: rtl/c1541_sd_server.sv
// Serves 512-byte SD block reads/writes from a byte-wide disk image, one byte per image access.
// Optional WRPROT_EN: wr_protect at write acceptance blocks all image writes for that block.
module c1541_sd_server #(
    parameter int IMG_BLOCKS = 768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_protect,
    output logic               busy,
    output logic               range_err,
    c1541_sd_server_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE, START, RD_FETCH, RD_PUT, WR_ADDR, WR_SAMPLE, WR_STORE, DONE, RELEASE
    } state_t;

    state_t      state_r, state_s;
    logic [14:0] lba_r, lba_s;
    logic [8:0]  cnt_r, cnt_s;
    logic        is_wr_r, is_wr_s;
    logic        no_img_r, no_img_s;
    logic        ack_r, ack_s;
    logic        bwr_r, bwr_s;
    logic        img_rd_r, img_rd_s;
    logic        img_wr_r, img_wr_s;
    logic        busy_r, busy_s;
    logic        rerr_r, rerr_s;
    logic [7:0]  dout_r, dout_s;
    logic [7:0]  img_din_r, img_din_s;
    logic        oor_s;
    logic        prot_s;
    logic        last_s;

`ifdef WRPROT_EN
    assign prot_s = wr_protect & bus.sd_wr & ~bus.sd_rd;
`else
    logic unused_s;
    assign unused_s = wr_protect;
    assign prot_s   = 1'b0;
`endif

    assign oor_s  = (bus.sd_lba >= 32'(IMG_BLOCKS));
    assign last_s = (cnt_r == 9'd511);

    // Next-state and next-output logic; no_img_r turns a block into a dummy transfer.
    always_comb begin
        state_s   = state_r;
        lba_s     = lba_r;
        cnt_s     = cnt_r;
        is_wr_s   = is_wr_r;
        no_img_s  = no_img_r;
        ack_s     = ack_r;
        bwr_s     = 1'b0;
        img_rd_s  = img_rd_r;
        img_wr_s  = img_wr_r;
        busy_s    = busy_r;
        rerr_s    = rerr_r;
        dout_s    = dout_r;
        img_din_s = img_din_r;
        case (state_r)
            IDLE: begin
                if (bus.sd_rd || bus.sd_wr) begin
                    lba_s    = bus.sd_lba[14:0];
                    cnt_s    = 9'd0;
                    busy_s   = 1'b1;
                    is_wr_s  = ~bus.sd_rd;
                    no_img_s = oor_s | prot_s;
                    rerr_s   = oor_s | prot_s;
                    state_s  = START;
                end else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                ack_s = 1'b1;
                if (is_wr_r) begin
                    state_s = WR_ADDR;
                end else begin
                    img_rd_s = ~no_img_r;
                    state_s  = RD_FETCH;
                end
            end
            RD_FETCH: begin
                if (no_img_r) begin
                    dout_s  = 8'h00;
                    bwr_s   = 1'b1;
                    state_s = RD_PUT;
                end else if (bus.img_ready) begin
                    dout_s   = bus.img_dout;
                    img_rd_s = 1'b0;
                    bwr_s    = 1'b1;
                    state_s  = RD_PUT;
                end else begin
                    state_s  = RD_FETCH;
                end
            end
            RD_PUT: begin
                if (last_s) begin
                    state_s  = DONE;
                end else begin
                    cnt_s    = cnt_r + 9'd1;
                    img_rd_s = ~no_img_r;
                    state_s  = RD_FETCH;
                end
            end
            WR_ADDR: begin
                state_s = WR_SAMPLE;
            end
            WR_SAMPLE: begin
                // Buffer data lags the address by one cycle, so it is taken here.
                if (no_img_r) begin
                    img_wr_s  = 1'b0;
                end else begin
                    img_din_s = bus.sd_buff_din;
                    img_wr_s  = 1'b1;
                end
                state_s = WR_STORE;
            end
            WR_STORE: begin
                if (no_img_r || bus.img_ready) begin
                    img_wr_s = 1'b0;
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        cnt_s   = cnt_r + 9'd1;
                        state_s = WR_ADDR;
                    end
                end else begin
                    state_s = WR_STORE;
                end
            end
            DONE: begin
                ack_s   = 1'b0;
                state_s = RELEASE;
            end
            RELEASE: begin
                if (!bus.sd_rd && !bus.sd_wr) begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered outputs; reset drops any image access at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            lba_r     <= 15'd0;
            cnt_r     <= 9'd0;
            is_wr_r   <= 1'b0;
            no_img_r  <= 1'b0;
            ack_r     <= 1'b0;
            bwr_r     <= 1'b0;
            img_rd_r  <= 1'b0;
            img_wr_r  <= 1'b0;
            busy_r    <= 1'b0;
            rerr_r    <= 1'b0;
            dout_r    <= 8'h00;
            img_din_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            lba_r     <= lba_s;
            cnt_r     <= cnt_s;
            is_wr_r   <= is_wr_s;
            no_img_r  <= no_img_s;
            ack_r     <= ack_s;
            bwr_r     <= bwr_s;
            img_rd_r  <= img_rd_s;
            img_wr_r  <= img_wr_s;
            busy_r    <= busy_s;
            rerr_r    <= rerr_s;
            dout_r    <= dout_s;
            img_din_r <= img_din_s;
        end
    end

    assign bus.sd_ack       = ack_r;
    assign bus.sd_buff_addr = cnt_r;
    assign bus.sd_buff_dout = dout_r;
    assign bus.sd_buff_wr   = bwr_r;
    assign bus.img_addr     = {lba_r, cnt_r};
    assign bus.img_rd       = img_rd_r;
    assign bus.img_wr       = img_wr_r;
    assign bus.img_din      = img_din_r;
    assign busy             = busy_r;
    assign range_err        = rerr_r;

endmodule

// File: tb/tb_c1541_sd_server.sv
// Randomized bench for c1541_sd_server: an image store with random latency, an initiator buffer,
// and a block-level reference image that predicts every byte a transfer must move.
module tb_c1541_sd_server;

    localparam int BLOCKS = 768;

    logic clk = 1'b0;
    logic reset;
    logic wr_protect;
    logic busy;
    logic range_err;

    c1541_sd_server_if ifc ();

    c1541_sd_server #(.IMG_BLOCKS(BLOCKS)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_protect (wr_protect),
        .busy       (busy),
        .range_err  (range_err),
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int unsigned addr; logic [7:0] data; } acc_t;
    typedef struct { int unsigned addr; logic [7:0] data; } strobe_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          max_dly = 0;
    int          fix_dly = 0;
    int          bwr_viol = 0;
    int          last_addr = -1;
    acc_t        accs[$];
    strobe_t     strobes[$];
    int          addr_seq[$];
    logic [7:0]  env_mem [int unsigned];
    logic [7:0]  ref_mem [int unsigned];
    logic [7:0]  wbuf [0:511];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int unsigned a);
        logic [7:0] b;
        b = a[7:0];
        return b ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_get(input int unsigned a);
        if (env_mem.exists(a)) return env_mem[a];
        else return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_get(input int unsigned a);
        if (ref_mem.exists(a)) return ref_mem[a];
        else return init_byte(a);
    endfunction

    function automatic logic [63:0] outs_packed();
        return {9'd0, ifc.sd_ack, ifc.sd_buff_wr, ifc.img_rd, ifc.img_wr, busy, range_err,
                ifc.sd_buff_addr, ifc.sd_buff_dout, ifc.img_addr, ifc.img_din};
    endfunction

    // Image store: answers each access after a (possibly random) delay and logs it.
    initial begin : image_store
        int d;
        int unsigned a;
        ifc.img_ready = 1'b0;
        ifc.img_dout  = 8'h00;
        forever begin
            @(negedge clk);
            if (ifc.img_rd || ifc.img_wr) begin
                d = (max_dly > 0) ? int'($urandom_range(0, max_dly)) : fix_dly;
                repeat (d) @(negedge clk);
                if (ifc.img_rd || ifc.img_wr) begin
                    a = ifc.img_addr;
                    if (ifc.img_wr) begin
                        env_mem[a] = ifc.img_din;
                        accs.push_back('{1'b1, a, ifc.img_din});
                        ifc.img_dout = 8'h00;
                    end else begin
                        ifc.img_dout = env_get(a);
                        accs.push_back('{1'b0, a, ifc.img_dout});
                    end
                    ifc.img_ready = 1'b1;
                    @(negedge clk);
                    ifc.img_ready = 1'b0;
                end
            end
        end
    end

    // Initiator buffer: data follows the address with one cycle of latency.
    initial begin : init_buffer
        int last;
        last = 0;
        ifc.sd_buff_din = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            ifc.sd_buff_din = wbuf[last];
            last = int'(ifc.sd_buff_addr);
        end
    end

    // Bus monitor: strobes, addresses presented under ack, strobes outside ack.
    always @(negedge clk) begin
        if (ifc.sd_buff_wr) begin
            strobes.push_back('{int'(ifc.sd_buff_addr), ifc.sd_buff_dout});
            if (!ifc.sd_ack) bwr_viol++;
        end
        if (ifc.sd_ack && int'(ifc.sd_buff_addr) != last_addr) begin
            addr_seq.push_back(int'(ifc.sd_buff_addr));
            last_addr = int'(ifc.sd_buff_addr);
        end
    end

    task automatic do_xfer(input bit rd, input bit wr, input int unsigned lba, input bit prot,
                           input int hold_extra);
        bit          blocked;
        int          lat;
        int          cyc;
        int          nbad;
        int unsigned base;
        logic [7:0]  expd;
        blocked = (lba >= BLOCKS);
`ifdef WRPROT_EN
        if (!rd && prot) blocked = 1'b1;
`endif
        base = lba * 512;
        strobes.delete();
        accs.delete();
        addr_seq.delete();
        last_addr = -1;
        @(negedge clk);
        ifc.sd_lba = lba;
        ifc.sd_rd  = rd;
        ifc.sd_wr  = wr;
        wr_protect = prot;
        lat = 0;
        while (!ifc.sd_ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ack_latency", lat, 2);
        if (hold_extra == 0) begin
            ifc.sd_rd = 1'b0;
            ifc.sd_wr = 1'b0;
        end
        cyc = 0;
        while (ifc.sd_ack && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("ack_fall", ifc.sd_ack, 1'b0);
        if (hold_extra != 0) begin
            repeat (hold_extra) @(negedge clk);
            check("busy_while_held", busy, 1'b1);
            check("no_restart", ifc.sd_ack, 1'b0);
            ifc.sd_rd = 1'b0;
            ifc.sd_wr = 1'b0;
        end
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_clear", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_no_ack", ifc.sd_ack, 1'b0);
        check("range_err", range_err, blocked);
        nbad = (addr_seq.size() == 512) ? 0 : 1;
        foreach (addr_seq[i]) if (addr_seq[i] != i) nbad++;
        check("addr_sequence", nbad, 0);
        if (rd) begin
            check("rd_strobes", strobes.size(), 512);
            nbad = 0;
            foreach (strobes[i]) begin
                expd = blocked ? 8'h00 : ref_get(base + i);
                if (strobes[i].addr != i || strobes[i].data !== expd) nbad++;
            end
            check("rd_data", nbad, 0);
            check("rd_img_count", accs.size(), blocked ? 0 : 512);
            nbad = 0;
            foreach (accs[i]) if (accs[i].wr || accs[i].addr != base + i) nbad++;
            check("rd_img_addr", nbad, 0);
        end else begin
            check("wr_strobes", strobes.size(), 0);
            check("wr_img_count", accs.size(), blocked ? 0 : 512);
            nbad = 0;
            foreach (accs[i])
                if (!accs[i].wr || accs[i].addr != base + i || accs[i].data !== wbuf[i]) nbad++;
            check("wr_img_data", nbad, 0);
            if (!blocked) for (int i = 0; i < 512; i++) ref_mem[base + i] = wbuf[i];
        end
    endtask

    initial begin : main
        int          cyc;
        bit          rd;
        bit          wr;
        int unsigned lba;
        reset         = 1'b1;
        wr_protect    = 1'b0;
        ifc.sd_lba    = 32'd0;
        ifc.sd_rd     = 1'b0;
        ifc.sd_wr     = 1'b0;
        for (int i = 0; i < 512; i++) wbuf[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_packed(), 64'd0);
        reset = 1'b0;

        // lba 5 read, ready one cycle after img_rd, request held past ack fall
        fix_dly = 1;
        do_xfer(1'b1, 1'b0, 32'd5, 1'b0, 6);

        // lba 3 write of n+1, then read it back
        fix_dly = 0;
        for (int i = 0; i < 512; i++) wbuf[i] = 8'(i + 1);
        do_xfer(1'b0, 1'b1, 32'd3, 1'b0, 0);
        do_xfer(1'b1, 1'b0, 32'd3, 1'b0, 0);

        // first out-of-range block
        do_xfer(1'b1, 1'b0, 32'd768, 1'b0, 0);

        // random image latency 0..7
        max_dly = 7;
        do_xfer(1'b1, 1'b0, $urandom_range(0, BLOCKS - 1), 1'b0, 0);
        max_dly = 0;

        // reset at byte 200 of a read, then a fresh read of lba 1
        strobes.delete();
        @(negedge clk);
        ifc.sd_lba = 32'd9;
        ifc.sd_rd  = 1'b1;
        cyc = 0;
        while (!ifc.sd_ack && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        ifc.sd_rd = 1'b0;
        cyc = 0;
        while (strobes.size() < 200 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_byte_200", strobes.size(), 200);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", outs_packed(), 64'd0);
        reset = 1'b0;
        do_xfer(1'b1, 1'b0, 32'd1, 1'b0, 0);

        // write with wr_protect high, then read the block back
        for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
        do_xfer(1'b0, 1'b1, 32'd2, 1'b1, 0);
        wr_protect = 1'b0;
        do_xfer(1'b1, 1'b0, 32'd2, 1'b0, 0);

        // read and write together: read is served
        do_xfer(1'b1, 1'b1, 32'd7, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            rd  = 1'($urandom);
            wr  = rd ? 1'($urandom) : 1'b1;
            lba = ($urandom_range(0, 4) == 0) ? 32'(BLOCKS) + $urandom_range(0, 40000)
                                              : $urandom_range(0, BLOCKS - 1);
            max_dly = $urandom_range(0, 3);
            for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
            do_xfer(rd, wr, lba, 1'($urandom), 0);
        end
        max_dly = 0;
        wr_protect = 1'b0;

        check("buff_wr_outside_ack", bwr_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
